session_timer_bank: RTL

//  Multi-channel successor to the single session timeout timer. NUM_CH independent timers share one

---
 rtl/session_timer_bank_pkg.sv | 26 ++
 rtl/session_timer_bank_if.sv | 26 ++
 rtl/session_timer_bank_timer_channel.sv | 111 +++++++++++
 rtl/session_timer_bank.sv | 67 ++++++
 4 files changed

// File: rtl/session_timer_bank_pkg.sv
// Shared types and helpers for the ATM session timer bank.
package atm_timer_pkg;

    localparam int TIMER_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } chan_state_e;

    // Subtract that floors at zero instead of wrapping.
    function automatic logic [TIMER_CNT_W-1:0] sat_sub(
        input logic [TIMER_CNT_W-1:0] a,
        input logic [TIMER_CNT_W-1:0] b
    );
        logic [TIMER_CNT_W-1:0] res;
        if (a > b) begin
            res = a - b;
        end else begin
            res = {TIMER_CNT_W{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/session_timer_bank_if.sv
// Control/status bundle between the ATM controller and the timer bank.
interface session_timer_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       restart;
    logic [NUM_CH-1:0]       auto_reload;
    logic [NUM_CH*CNT_W-1:0] threshold;
    logic [CNT_W-1:0]        warn_margin;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       timeout;
    logic [NUM_CH-1:0]       expired_pulse;
    logic [NUM_CH-1:0]       warning;
    logic                    any_timeout;

    modport master (
        output start, restart, auto_reload, threshold, warn_margin, ack,
        input  timeout, expired_pulse, warning, any_timeout
    );

    modport slave (
        input  start, restart, auto_reload, threshold, warn_margin, ack,
        output timeout, expired_pulse, warning, any_timeout
    );
endinterface

// File: rtl/session_timer_bank_timer_channel.sv
// One timer channel: IDLE/RUN/EXPIRED FSM, counter, sticky timeout and warning.
// CNT_W is expected to be no wider than TIMER_CNT_W (the sat_sub width).
module timer_channel
    import atm_timer_pkg::*;
#(
    parameter int CNT_W = TIMER_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             restart_i,
    input  logic             auto_reload_i,
    input  logic             ack_i,
    input  logic [CNT_W-1:0] threshold_i,
    input  logic [CNT_W-1:0] warn_margin_i,
    output logic             timeout_o,
    output logic             expired_pulse_o,
    output logic             warning_o
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             pulse_q, pulse_d;
    logic             expire_s;
    logic [CNT_W-1:0] warn_floor_s;

    // Next state and counter; start=0 dominates, then restart, then tick/expiry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        expire_s = 1'b0;
        if (!start_i) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end
                ST_RUN: begin
                    if (restart_i) begin
                        cnt_d = CNT_ZERO;
                    end else if (tick_i) begin
                        if (cnt_q == threshold_i) begin
                            expire_s = 1'b1;
                            if (auto_reload_i) begin
                                cnt_d = CNT_ZERO;
                            end else begin
                                state_d = ST_EXPIRED;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_EXPIRED: begin
                    if (restart_i) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_EXPIRED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Expiry pulse and sticky flag; a new expiry beats a simultaneous ack.
    always_comb begin
        pulse_d = expire_s;
        if (expire_s) begin
            timeout_d = 1'b1;
        end else if (ack_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State, counter and output flag registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            timeout_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            pulse_q   <= pulse_d;
        end
    end

    assign warn_floor_s    = CNT_W'(sat_sub(TIMER_CNT_W'(threshold_i), TIMER_CNT_W'(warn_margin_i)));
    assign warning_o       = (state_q == ST_RUN) && (cnt_q >= warn_floor_s);
    assign timeout_o       = timeout_q;
    assign expired_pulse_o = pulse_q;

endmodule

// File: rtl/session_timer_bank.sv
// Bank of independent session timers sharing one free-running prescaler.
module session_timer_bank
    import atm_timer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = TIMER_CNT_W,
    parameter int PRESCALE = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    session_timer_bank_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRSC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRSC_ONE  = PW'(32'd1);

    logic [PW-1:0]     prsc_q, prsc_d;
    logic              tick_s;
    logic [NUM_CH-1:0] timeout_s;
    logic [NUM_CH-1:0] pulse_s;
    logic [NUM_CH-1:0] warning_s;

    assign tick_s = (prsc_q == PRSC_LAST);

    // Prescaler wraps after PRESCALE cycles; tick marks the last cycle.
    always_comb begin
        if (tick_s) begin
            prsc_d = {PW{1'b0}};
        end else begin
            prsc_d = prsc_q + PRSC_ONE;
        end
    end

    // Prescaler register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prsc_q <= {PW{1'b0}};
        end else begin
            prsc_q <= prsc_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .tick_i         (tick_s),
            .start_i        (bus.start[gi]),
            .restart_i      (bus.restart[gi]),
            .auto_reload_i  (bus.auto_reload[gi]),
            .ack_i          (bus.ack[gi]),
            .threshold_i    (bus.threshold[gi*CNT_W +: CNT_W]),
            .warn_margin_i  (bus.warn_margin),
            .timeout_o      (timeout_s[gi]),
            .expired_pulse_o(pulse_s[gi]),
            .warning_o      (warning_s[gi])
        );
    end

    assign bus.timeout       = timeout_s;
    assign bus.expired_pulse = pulse_s;
    assign bus.warning       = warning_s;
    assign bus.any_timeout   = |timeout_s;

endmodule
